// File: rtl/timer_pkg.sv
// Shared types and constants for the timer blocks in the sequential library.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  localparam int DEFAULT_TIMER_WIDTH = 8;

endpackage

// File: rtl/load_down_timer.sv
// Loadable down-counting timer: a valid/ready load, one-shot or auto-reload
// mode, and a registered one-cycle terminal-count pulse.
module load_down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             reload_en,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  timer_state_t     state;
  logic [WIDTH-1:0] period_reg;
  logic             mode_reg;

  assign busy       = (state == RUN);
  assign load_ready = (state == IDLE);

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others; blocking '=' would
  // make the result depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= ZERO;
      period_reg <= ZERO;
      mode_reg   <= 1'b0;
      tc_pulse   <= 1'b0;
    end else begin
      tc_pulse <= 1'b0;
      if (abort) begin
        state <= IDLE;
        count <= ZERO;
      end else begin
        unique case (state)
          IDLE: begin
            if (load_valid) begin
              count      <= load_data;
              period_reg <= load_data;
              mode_reg   <= reload_en;
              if (load_data != ZERO) state <= RUN;
            end
          end
          RUN: begin
            if (enable) begin
              if (count == ONE) begin
                tc_pulse <= 1'b1;
                if (mode_reg) begin
                  count <= period_reg;
                end else begin
                  count <= ZERO;
                  state <= IDLE;
                end
              end else if (count > ONE) begin
                // Guarded so a stray zero count in RUN holds instead of wrapping.
                count <= count - ONE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_load_down_timer.sv
// Scoreboard bench for load_down_timer: stimulus pushes expected post-edge
// outputs, a monitor pops and compares them on the falling edge.
module tb_load_down_timer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             reload_en;
  logic             enable;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc_pulse;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    string            name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  load_down_timer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .reload_en  (reload_en),
    .enable     (enable),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .tc_pulse   (tc_pulse)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge, then queue the
  // outputs expected after the next rising edge.
  task automatic step(input logic lv, input logic [WIDTH-1:0] ld, input logic re,
                      input logic en, input logic ab,
                      input logic [WIDTH-1:0] e_count, input logic e_busy,
                      input logic e_tc, input string name);
    exp_t e;
    load_valid = lv;
    load_data  = ld;
    reload_en  = re;
    enable     = en;
    abort      = ab;
    @(posedge clk);
    #1;
    e.count = e_count;
    e.busy  = e_busy;
    e.tc    = e_tc;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".count"},      32'(count),      32'(e.count));
        check({e.name, ".busy"},       32'(busy),       32'(e.busy));
        check({e.name, ".tc_pulse"},   32'(tc_pulse),   32'(e.tc));
        check({e.name, ".load_ready"}, 32'(load_ready), 32'(!e.busy));
      end
    end
  end

  initial begin : stimulus
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    reload_en  = 1'b0;
    enable     = 1'b0;
    abort      = 1'b0;

    #3;
    check("reset.count",      32'(count),      32'd0);
    check("reset.busy",       32'(busy),       32'd0);
    check("reset.load_ready", 32'(load_ready), 32'd1);
    check("reset.tc_pulse",   32'(tc_pulse),   32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 0, 0, 1, 0, 0, 0, 0, "idle_after_reset");

    // One-shot D=3, then a back-to-back load in the tc cycle.
    step(1, 3, 0, 1, 0, 3, 1, 0, "os_load3");
    step(0, 0, 0, 1, 0, 2, 1, 0, "os_c2");
    step(0, 0, 0, 1, 0, 1, 1, 0, "os_c1");
    step(0, 0, 0, 1, 0, 0, 0, 1, "os_tc");
    step(1, 2, 0, 1, 0, 2, 1, 0, "b2b_load2");
    step(0, 0, 0, 1, 0, 1, 1, 0, "b2b_c1");
    step(0, 0, 0, 1, 0, 0, 0, 1, "b2b_tc");
    step(0, 0, 0, 1, 0, 0, 0, 0, "b2b_idle");

    // Auto-reload D=4 with a two-cycle pause at count=2.
    step(1, 4, 1, 1, 0, 4, 1, 0, "ar_load4");
    step(0, 0, 0, 1, 0, 3, 1, 0, "ar_c3");
    step(0, 0, 0, 1, 0, 2, 1, 0, "ar_c2");
    step(0, 0, 0, 0, 0, 2, 1, 0, "ar_pause1");
    step(0, 0, 0, 0, 0, 2, 1, 0, "ar_pause2");
    step(0, 0, 0, 1, 0, 1, 1, 0, "ar_c1");
    step(0, 0, 0, 1, 0, 4, 1, 1, "ar_tc1");
    step(0, 0, 0, 1, 0, 3, 1, 0, "ar_r3");
    step(0, 0, 0, 1, 0, 2, 1, 0, "ar_r2");
    step(0, 0, 0, 1, 0, 1, 1, 0, "ar_r1");
    step(0, 0, 0, 1, 0, 4, 1, 1, "ar_tc2");
    step(0, 0, 0, 1, 1, 0, 0, 0, "ar_abort");

    // Zero load stays idle; loads during RUN are ignored.
    step(1, 0, 1, 1, 0, 0, 0, 0, "zero_load");
    step(0, 0, 0, 1, 0, 0, 0, 0, "zero_idle");
    step(1, 5, 0, 1, 0, 5, 1, 0, "blk_load5");
    step(1, 9, 0, 1, 0, 4, 1, 0, "blk_ignored_en");
    step(1, 9, 0, 0, 0, 4, 1, 0, "blk_ignored_hold");
    step(0, 0, 0, 1, 0, 3, 1, 0, "blk_c3");
    step(0, 0, 0, 1, 0, 2, 1, 0, "blk_c2");
    step(0, 0, 0, 1, 0, 1, 1, 0, "blk_c1");

    // Abort at count==1 suppresses tc; abort in IDLE blocks a load.
    step(0, 0, 0, 1, 1, 0, 0, 0, "abort_at1");
    step(0, 0, 0, 1, 0, 0, 0, 0, "abort_no_tc");
    step(1, 7, 0, 1, 1, 0, 0, 0, "abort_blocks_load");
    step(0, 0, 0, 1, 0, 0, 0, 0, "abort_still_idle");

    // Auto-reload with period 1 pulses every cycle.
    step(1, 1, 1, 1, 0, 1, 1, 0, "p1_load");
    step(0, 0, 0, 1, 0, 1, 1, 1, "p1_tc1");
    step(0, 0, 0, 1, 0, 1, 1, 1, "p1_tc2");
    step(0, 0, 0, 1, 1, 0, 0, 0, "p1_abort");

    // Full-range one-shot: tc exactly 255 cycles after acceptance, no wrap.
    step(1, 255, 0, 1, 0, 255, 1, 0, "max_load");
    for (int k = 1; k < 255; k++)
      step(0, 0, 0, 1, 0, WIDTH'(255 - k), 1, 0, "max_run");
    step(0, 0, 0, 1, 0, 0, 0, 1, "max_tc");
    step(0, 0, 0, 1, 0, 0, 0, 0, "max_no_wrap");

    // Mid-run asynchronous reset.
    step(1, 5, 0, 1, 0, 5, 1, 0, "mr_load5");
    step(0, 0, 0, 1, 0, 4, 1, 0, "mr_c4");
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset.count",      32'(count),      32'd0);
    check("midrun_reset.busy",       32'(busy),       32'd0);
    check("midrun_reset.load_ready", 32'(load_ready), 32'd1);
    check("midrun_reset.tc_pulse",   32'(tc_pulse),   32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 0, 0, 1, 0, 0, 0, 0, "after_midrun_reset");
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
